// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/branch/memory-wait stall and flush control for a 5-stage pipeline; optional HAZARD_STATS_EN adds stall/flush counters
module hazard_ctrl #(
  parameter int BR_FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_MemRead,
  input  logic [4:0] ex_rt,
  input  logic       branch_taken,
  input  logic       mem_busy,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       exmem_flush,
  output logic       pipe_hold,
  output logic       flush_active,
  output logic       mem_timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  localparam int BW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] BMAX = BW'(MEM_TIMEOUT);
  localparam logic [3:0] FINIT = 4'(BR_FLUSH_CYCLES - 1);
  typedef enum logic {RUN, BR_FLUSH} state_t;
  state_t state, state_nxt;
  logic [3:0] fcnt, fcnt_nxt;
  logic [BW-1:0] bcnt, bcnt_inc;
  logic load_use, br_go, lu_go;
  assign load_use = ex_MemRead && ex_rt != 5'd0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  assign bcnt_inc = (bcnt == BMAX) ? bcnt : bcnt + 1'b1;
  assign flush_active = !rst && state == BR_FLUSH;
  // priority resolution: rst, mem_busy, then flush/branch, then load-use
  always_comb begin
    state_nxt = state;
    fcnt_nxt = fcnt;
    pc_write = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold = 1'b0;
    br_go = 1'b0;
    lu_go = 1'b0;
    if (!rst) begin
      if (mem_busy) begin
        pipe_hold = 1'b1;
      end else if (state == BR_FLUSH) begin
        pc_write = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
        idex_bubble = 1'b1;
        fcnt_nxt = fcnt - 4'd1;
        state_nxt = (fcnt == 4'd1) ? RUN : BR_FLUSH;
      end else if (branch_taken) begin
        pc_write = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
        br_go = 1'b1;
        state_nxt = (BR_FLUSH_CYCLES > 1) ? BR_FLUSH : RUN;
        fcnt_nxt = (BR_FLUSH_CYCLES > 1) ? FINIT : fcnt;
      end else if (load_use) begin
        idex_bubble = 1'b1;
        lu_go = 1'b1;
      end else begin
        pc_write = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end
  // state, counters and sticky watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fcnt <= 4'd0;
      bcnt <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      fcnt <= fcnt_nxt;
      bcnt <= mem_busy ? bcnt_inc : '0;
      mem_timeout <= mem_timeout | (MEM_TIMEOUT != 0 && mem_busy && bcnt_inc == BMAX);
    end
  end
`ifdef HAZARD_STATS_EN
  // event counters, free-running modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      stall_cnt <= stall_cnt + 32'(mem_busy || lu_go);
      flush_cnt <= flush_cnt + 32'(br_go);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (BR_FLUSH_CYCLES=3, MEM_TIMEOUT=4)
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, ex_MemRead, branch_taken, mem_busy;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold, flush_active, mem_timeout;
  logic [6:0] outs;
  int checks = 0;
  int errors = 0;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  always #5 clk = ~clk;
  hazard_ctrl #(.BR_FLUSH_CYCLES(3), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_flush(exmem_flush), .pipe_hold(pipe_hold), .flush_active(flush_active), .mem_timeout(mem_timeout)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );
  assign outs = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold, flush_active};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic urt, input logic mr,
                     input logic [4:0] ert, input logic br, input logic busy);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_MemRead = mr; ex_rt = ert; branch_taken = br; mem_busy = busy;
  endtask
  task automatic step(input string tag, input logic [6:0] exp);
    #2;
    chk(tag, 32'(outs), 32'(exp));
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    drv(5, 5, 1, 1, 5, 1, 0);
    step("rst_outs", 7'b0000000);
    chk("rst_timeout", 32'(mem_timeout), 0);
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    step("run_idle", 7'b1100000);
    drv(5, 1, 0, 1, 5, 0, 0);
    step("lu_rs", 7'b0001000);
    drv(5, 1, 0, 0, 5, 0, 0);
    step("lu_clear", 7'b1100000);
    drv(3, 7, 1, 1, 7, 0, 0);
    step("lu_rt", 7'b0001000);
    drv(3, 7, 0, 1, 7, 0, 0);
    step("lu_rt_unused", 7'b1100000);
    drv(0, 0, 1, 1, 0, 0, 0);
    step("lu_r0", 7'b1100000);
    drv(5, 5, 1, 1, 5, 1, 0);
    step("br_lu", 7'b1111100);
    drv(5, 5, 1, 1, 5, 1, 0);
    step("flush2_ignore", 7'b1111001);
    step("flush3_ignore", 7'b1111001);
    drv(0, 0, 0, 0, 0, 0, 0);
    step("after_flush", 7'b1100000);
    drv(0, 0, 0, 0, 0, 1, 0);
    step("br2", 7'b1111100);
    drv(0, 0, 0, 0, 0, 0, 0);
    step("hflush2", 7'b1111001);
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 0, 0, 0, 0, 1);
      step("flush_hold", 7'b0000011);
      if (i == 2) chk("wd_pre", 32'(mem_timeout), 0);
    end
    chk("wd_set", 32'(mem_timeout), 1);
    drv(0, 0, 0, 0, 0, 0, 0);
    step("hflush3_resume", 7'b1111001);
    step("hrun_after", 7'b1100000);
    chk("wd_sticky", 32'(mem_timeout), 1);
    rst = 1'b1;
    step("rst_outs2", 7'b0000000);
    rst = 1'b0;
    chk("wd_clr", 32'(mem_timeout), 0);
    for (int i = 0; i < 6; i++) begin
      drv(0, 0, 0, 0, 0, 0, 1);
      step("busy_hold", 7'b0000010);
      if (i == 2) chk("wd6_pre", 32'(mem_timeout), 0);
      if (i == 3) chk("wd6_set", 32'(mem_timeout), 1);
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    step("busy_release", 7'b1100000);
    chk("wd6_sticky", 32'(mem_timeout), 1);
    drv(0, 0, 0, 0, 0, 1, 1);
    step("br_busy", 7'b0000010);
    drv(0, 0, 0, 0, 0, 1, 0);
    step("br_repres", 7'b1111100);
    drv(0, 0, 0, 0, 0, 0, 0);
    step("rflush2", 7'b1111001);
    rst = 1'b1;
    step("rst_mid", 7'b0000000);
    rst = 1'b0;
    chk("rst_wd", 32'(mem_timeout), 0);
    step("rst_mid_run", 7'b1100000);
`ifdef HAZARD_STATS_EN
    chk("stats_zero", stall_cnt, 0);
    drv(9, 0, 0, 1, 9, 0, 0);
    step("s_lu1", 7'b0001000);
    step("s_lu2", 7'b0001000);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0, 1);
      step("s_busy", 7'b0000010);
    end
    drv(0, 0, 0, 0, 0, 1, 0);
    step("s_br", 7'b1111100);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("stall_cnt", stall_cnt, 5);
    chk("flush_cnt", flush_cnt, 1);
    rst = 1'b1;
    step("s_rst", 7'b0000000);
    rst = 1'b0;
    chk("stall_rst", stall_cnt, 0);
    chk("flush_rst", flush_cnt, 0);
    step("s_run", 7'b1100000);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
